// File: rtl/ps2_packet_tx.sv
// PS/2 packet transmitter: takes a whole multi-byte packet on a valid/ready
// handshake and shifts it out as start/8 data LSB-first/odd parity/stop frames.
module ps2_packet_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int BYTES        = 3,
    parameter int GAP_BITS     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [8*BYTES-1:0]   in_data,
    output logic                 in_ready,
    output logic                 tx_data,
    output logic                 busy,
    output logic                 byte_done,
    output logic                 packet_done,
    output logic                 sync_err
);

    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int MAXC     = (GAP_CLKS > CLKS_PER_BIT) ? GAP_CLKS : CLKS_PER_BIT;
    localparam int CW       = $clog2(MAXC + 1);
    localparam int IW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] BIT_LD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GAP_LD = CW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [IW-1:0]      r_idx, w_idx_nxt;
    logic [8*BYTES-1:0] r_pkt, w_pkt_nxt;
    logic               r_tx, w_tx_nxt;
    logic               r_sync_err, w_sync_err_nxt;

    logic [7:0] w_cur;
    logic       w_last_clk;
    logic       w_last_byte;

    // The byte on the wire is always the top of r_pkt; it is shifted on leaving STOP.
    assign w_cur       = r_pkt[8*BYTES-1 -: 8];
    assign w_last_clk  = (r_cnt == '0);
    assign w_last_byte = (r_idx == IW'(BYTES - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_last_clk ? r_cnt : r_cnt - CW'(1);
        w_bit_nxt      = r_bit;
        w_idx_nxt      = r_idx;
        w_pkt_nxt      = r_pkt;
        w_sync_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_data[8*BYTES-5]) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = BIT_LD;
                        w_pkt_nxt   = in_data;
                        w_idx_nxt   = '0;
                    end else begin
                        w_sync_err_nxt = 1'b1;
                    end
                end
            end
            S_START: begin
                if (w_last_clk) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                    w_cnt_nxt   = BIT_LD;
                end
            end
            S_DATA: begin
                if (w_last_clk) begin
                    w_cnt_nxt = BIT_LD;
                    if (r_bit == 3'd7) w_state_nxt = S_PARITY;
                    else               w_bit_nxt   = r_bit + 3'd1;
                end
            end
            S_PARITY: begin
                if (w_last_clk) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = BIT_LD;
                end
            end
            S_STOP: begin
                if (w_last_clk) begin
                    if (w_last_byte) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pkt_nxt = r_pkt << 8;
                        w_idx_nxt = r_idx + IW'(1);
                        if (GAP_CLKS == 0) begin
                            w_state_nxt = S_START;
                            w_cnt_nxt   = BIT_LD;
                        end else begin
                            w_state_nxt = S_GAP;
                            w_cnt_nxt   = GAP_LD;
                        end
                    end
                end
            end
            S_GAP: begin
                if (w_last_clk) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = BIT_LD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line level is decided from the state being entered so tx_data stays aligned with r_state.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_cur[w_bit_nxt];
            S_PARITY: w_tx_nxt = ~^w_cur;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_idx      <= '0;
            r_pkt      <= '0;
            r_tx       <= 1'b1;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_idx      <= w_idx_nxt;
            r_pkt      <= w_pkt_nxt;
            r_tx       <= w_tx_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign tx_data     = r_tx;
    assign byte_done   = (r_state == S_STOP) && w_last_clk;
    assign packet_done = byte_done && w_last_byte;
    assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_ps2_packet_tx.sv
// Directed bench for ps2_packet_tx: frame contents/timing, sync reject,
// held-valid spacing, mid-packet reset and a fast-timing loopback decode.
module tb_ps2_packet_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_valid2;
    logic [23:0] in_data, in_data2;
    logic        in_ready, tx_data, busy, byte_done, packet_done, sync_err;
    logic        in_ready2, tx_data2, busy2, byte_done2, packet_done2, sync_err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps2_packet_tx #(.CLKS_PER_BIT(4), .BYTES(3), .GAP_BITS(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_data(tx_data), .busy(busy), .byte_done(byte_done),
        .packet_done(packet_done), .sync_err(sync_err)
    );

    ps2_packet_tx #(.CLKS_PER_BIT(1), .BYTES(3), .GAP_BITS(0)) u_dut_lb (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .tx_data(tx_data2), .busy(busy2), .byte_done(byte_done2),
        .packet_done(packet_done2), .sync_err(sync_err2)
    );

    // Frames written first-sent bit at MSB: start, d0..d7, parity, stop.
    localparam logic [10:0] F08 = 11'b0_00010000_0_1;
    localparam logic [10:0] F00 = 11'b0_00000000_1_1;
    localparam logic [10:0] FFF = 11'b0_11111111_1_1;
    localparam logic [10:0] F09 = 11'b0_10010000_1_1;
    localparam logic [10:0] F81 = 11'b0_10000001_1_1;
    localparam logic [10:0] F7E = 11'b0_01111110_1_1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with in_ready=1; returns at the negedge of cycle 1.
    task automatic handshake(input logic [23:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Checks cycles 1..148 of a default-timing packet; returns at cycle 149's negedge.
    task automatic check_pkt(input logic [10:0] f0, input logic [10:0] f1, input logic [10:0] f2);
        logic [10:0] f [3];
        logic        exp_tx, exp_bd;
        int          p, k, off;
        f[0] = f0; f[1] = f1; f[2] = f2;
        for (int c = 1; c <= 148; c++) begin
            p      = c - 1;
            k      = p / 52;
            off    = p % 52;
            exp_tx = (off < 44) ? f[k][10 - off/4] : 1'b1;
            exp_bd = (c == 44) || (c == 96) || (c == 148);
            check($sformatf("pkt_c%0d", c),
                  {27'd0, tx_data, busy, in_ready, byte_done, packet_done},
                  {27'd0, exp_tx, 1'b1, 1'b0, exp_bd, (c == 148)});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [23:0] d;
        logic [32:0] bits;
        logic [7:0]  b;
        int          n_bound;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_valid2 = 1'b0;
        in_data2  = '0;
        repeat (3) @(negedge clk);
        check("rst_state", {26'd0, tx_data, in_ready, busy, byte_done, packet_done, sync_err},
              {26'd0, 6'b110000});
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {26'd0, tx_data, in_ready, busy, byte_done, packet_done, sync_err},
                  {26'd0, 6'b110000});
        end

        // Basic packet with default timing.
        handshake(24'h08_00_FF);
        check_pkt(F08, F00, FFF);
        check("end_idle", {27'd0, tx_data, busy, in_ready, byte_done, packet_done},
              {27'd0, 5'b10100});

        // Bit 3 of first byte clear: consumed and rejected.
        handshake(24'h00_12_34);
        check("sync_err1", {28'd0, sync_err, tx_data, in_ready, busy}, {28'd0, 4'b1110});
        @(negedge clk);
        check("sync_err2", {28'd0, sync_err, tx_data, in_ready, busy}, {28'd0, 4'b0110});

        // in_valid held high; in_data swapped right after the first handshake.
        in_data  = 24'h08_00_FF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 24'h09_81_7E;
        check_pkt(F08, F00, FFF);
        check("gap_idle", {30'd0, tx_data, in_ready}, {30'd0, 2'b11});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_pkt(F09, F81, F7E);
        check("end_idle2", {27'd0, tx_data, busy, in_ready, byte_done, packet_done},
              {27'd0, 5'b10100});

        // Reset in cycle 60 (line is low there: byte 1 data bit 0).
        handshake(24'h08_00_FF);
        repeat (59) @(negedge clk);
        check("pre_rst", {30'd0, tx_data, busy}, {30'd0, 2'b01});
        #2 reset_n = 1'b0;
        #1 check("async_rst", {29'd0, tx_data, busy, in_ready}, {29'd0, 3'b101});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_hold", {29'd0, tx_data, byte_done, packet_done}, {29'd0, 3'b100});
        end
        reset_n = 1'b1;
        @(negedge clk);
        handshake(24'h08_00_FF);
        check_pkt(F08, F00, FFF);

        // Loopback decode at one clock per bit, no gap.
        n_bound = 0;
        for (int n = 0; n < 10; n++) begin
            d      = 24'($urandom());
            d[19]  = 1'b1;
            in_data2  = d;
            in_valid2 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid2 = 1'b0;
            for (int c = 0; c < 33; c++) begin
                bits[32 - c] = tx_data2;
                if (packet_done2) n_bound++;
                @(negedge clk);
            end
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < 8; i++) b[i] = bits[31 - 11*j - i];
                check($sformatf("lb_p%0d_b%0d", n, j),
                      {21'd0, bits[32 - 11*j], bits[22 - 11*j], ^{b, bits[23 - 11*j]}, b},
                      {21'd0, 1'b0, 1'b1, 1'b1, d[23 - 8*j -: 8]});
            end
            check("lb_ready", {31'd0, in_ready2}, 32'd1);
        end
        check("lb_bounds", n_bound, 32'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_packet_tx.md
Name: ps2_packet_tx

Overview:
- Transmit-side counterpart of the PS/2 mouse packet receiver.
- Accepts a complete multi-byte mouse packet over a valid/ready handshake and serializes it onto a single-bit line as standard PS/2 frames: start, 8 data bits LSB first, odd parity, stop.
- Bytes within a packet are separated by a fixed idle gap.
- Drives the test-stimulus side of the PS/2 path and any loopback into the receiver/boundary detector.

Parameters:
CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1)
BYTES, 3, bytes per packet (>=1)
GAP_BITS, 2, idle (line=1) bit periods inserted between bytes of one packet (>=0)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  packet offered
in_data  input  8*BYTES  packet; first-sent byte is in_data[8*BYTES-1 -: 8]
in_ready  output  1  block idle and able to accept a packet
tx_data  output  1  serial line, idles high
busy  output  1  packet in transmission
byte_done  output  1  one-cycle pulse on last cycle of each stop bit
packet_done  output  1  one-cycle pulse on last cycle of final stop bit
sync_err  output  1  one-cycle pulse: packet rejected

Behaviour:
- Reset (asynchronous on reset_n low; released synchronously):
  - state=IDLE; tx_data=1; busy=0; all pulses 0; in_ready=1.
  - Handshakes are ignored while reset is asserted.
  - Reset mid-packet aborts immediately: line returns to 1 and no done pulses are generated.
- in_ready = (state==IDLE), combinational. A handshake is in_valid&in_ready at a rising edge. Packet and byte index are captured at that edge.
- Sync check:
  - If bit 3 of the first byte (in_data[8*BYTES-5]) is 0, the packet is consumed but discarded.
  - sync_err=1 for the next cycle; state stays IDLE; tx_data stays 1.
- State machine: IDLE -> START -> DATA(8 bits) -> PARITY -> STOP -> (GAP -> START for next byte | IDLE after last byte).
- Bit timing: a down-counter holds each bit for exactly CLKS_PER_BIT cycles. tx_data is registered.
- Line values per state:
  - START: 0.
  - DATA: byte[i] for i=0..7.
  - PARITY: ~^byte (total ones across data+parity is odd).
  - STOP: 1.
  - GAP: 1 for GAP_BITS*CLKS_PER_BIT cycles. The GAP state is skipped when GAP_BITS=0 or after the last byte.
- Latency: the start bit appears on tx_data in the first cycle after the handshake edge.
- Packet duration T = BYTES*11*CLKS_PER_BIT + (BYTES-1)*GAP_BITS*CLKS_PER_BIT cycles from that first cycle.
- busy=1 for exactly those T cycles.
- Pulses:
  - byte_done pulses in the last STOP cycle of every byte.
  - packet_done coincides with the final byte_done.
- After the final STOP cycle, state returns to IDLE and in_ready=1. Minimum handshake-to-handshake spacing is T+1 cycles; no back-to-back acceptance inside a packet.
- in_data is don't-care after the handshake. Changes to it must not affect the transmission in progress.
- in_valid while busy is ignored and is not queued.
- BYTES=1 sends one frame with no gap.

Test Plan:
- Reset, then hold idle 20 cycles, defaults -> tx_data=1, in_ready=1, busy=0, no pulses.
- Send in_data=24'h08_00_FF (defaults) -> T=148 cycles.
  - Byte 0x08 frame: 0,0,0,0,1,0,0,0,0,0,1.
  - Byte 0x00 frame: 0, eight 0s, parity 1, stop 1.
  - Byte 0xFF frame: 0, eight 1s, parity 1, stop 1.
  - Each bit lasts 4 cycles, with 8 idle-high cycles between frames.
  - byte_done pulses at cycles 44, 96, 148; packet_done at cycle 148; in_ready=1 at cycle 149.
- in_data=24'h00_12_34 offered -> accepted, sync_err=1 for one cycle, tx_data stays 1, in_ready stays 1.
- in_valid held high with two packets queued by the driver -> second handshake occurs exactly T+1 cycles after the first; line shows 1 on the intervening IDLE cycle.
- reset_n pulsed low at cycle 60 of a packet -> tx_data=1 and busy=0 asynchronously; no byte_done/packet_done; next packet transmits correctly from its start bit.
- Loopback into the receiver with CLKS_PER_BIT=1, GAP_BITS=0, 10 random packets with bit3=1 -> receiver reports 10 boundaries with matching bytes.
